lstm_seq_ctrl: RTL and testbench
================================

LSTM_SEQ_CTRL -- requirements
Module: lstm_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, is the signed Q8.8 data width shared with the LSTM cell.
REQ-002 Parameter LEN_W, default 16, is the width of the sequence-length counter.
REQ-003 Parameter TIMEOUT, default 15, is the maximum number of cycles from cell accept to cell valid before an error is flagged.
REQ-004 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-005 cfg_gate  in  2  gate index (0=i, 1=f, 2=g, 3=o).
REQ-006 cfg_sel  in  2  target register (0=weight_x, 1=weight_h, 2=bias_x, 3=bias_h).
REQ-007 cfg_data  in  WIDTH  coefficient; cfg_valid  in  1; cfg_ready  out  1.
REQ-008 start  in  1  start pulse; seq_len  in  LEN_W  samples in the sequence; clear_state  in  1  zero h/C at start.
REQ-009 busy  out  1; done  out  1  one-cycle pulse; error  out  1  sticky timeout flag.
REQ-010 s_x  in  WIDTH; s_x_valid  in  1; s_x_ready  out  1  input sample stream.
REQ-011 m_y  out  WIDTH; m_y_valid  out  1; m_y_ready  in  1  output h stream.
REQ-012 final_c  out  WIDTH  cell state after the last sample.
REQ-013 Cell side: cell_ready in 1; cell_x, cell_h, cell_c out WIDTH each; cell_x_valid, cell_h_valid, cell_c_valid out 1 each; cell_weight_x, cell_weight_h, cell_bias_x, cell_bias_h out 4xWIDTH each; matching *_valid out 4 each; cell_y, cell_c_out in WIDTH each; cell_valid in 1.

Function
REQ-014 The FSM SHALL have states IDLE, INIT, ISSUE, WAIT, DONE.
REQ-015 cfg_ready SHALL equal (state==IDLE && cell_ready).
REQ-016 A cfg handshake SHALL drive cfg_data onto all four lanes of the selected cell bus, with exactly one valid bit high (lane cfg_gate) for that cycle only.
REQ-017 In IDLE, start with seq_len==0 SHALL go to DONE without touching the cell.
REQ-018 In IDLE, start with seq_len>0 SHALL load the counter to 0, assert busy, and go to INIT if clear_state=1, else to ISSUE.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 In INIT, when cell_ready=1, the block SHALL drive cell_h=0, cell_c=0, cell_h_valid=1, cell_c_valid=1 for one cycle, then go to ISSUE.
REQ-021 s_x_ready and cell_x_valid SHALL be combinational: s_x_ready = (ISSUE && cell_ready && !m_y_valid), cell_x_valid = s_x_ready && s_x_valid, cell_x = s_x.
REQ-022 An input handshake SHALL move the FSM to WAIT and clear the timeout counter.
REQ-023 In WAIT, cell_valid SHALL capture cell_y into m_y, set m_y_valid, capture cell_c_out into final_c, and increment the counter.
REQ-024 After that capture, if the counter equals seq_len the FSM SHALL go to DONE, else to ISSUE.
REQ-025 m_y_valid SHALL hold m_y stable until m_y_ready=1; the next sample SHALL NOT issue while m_y_valid=1.
REQ-026 In DONE, done SHALL pulse for one cycle, busy SHALL drop, and the FSM SHALL return to IDLE.
REQ-027 An m_y output still pending in DONE SHALL remain valid until consumed.
REQ-028 If the timeout counter in WAIT reaches TIMEOUT, error SHALL set and the FSM SHALL go to IDLE without a done pulse.
REQ-029 error SHALL clear only on rst or on an accepted start.
REQ-030 All cell_* valid outputs SHALL be 0 outside their qualifying cycle.
REQ-031 h/C feedback between samples SHALL be left to the cell; the block SHALL NOT drive cell_h_valid or cell_c_valid outside INIT.

Reset
REQ-032 On rst, state SHALL be IDLE.
REQ-033 On rst, the counter, busy, done, error, m_y, m_y_valid, final_c and all cell_* outputs SHALL be 0; rst mid-sequence SHALL abort with no done pulse.

Structure
REQ-034 Package lstm_pkg SHALL hold the gate enum {i,f,g,o}, the cfg_sel enum, the FSM state enum, and CELL_LATENCY=7.
REQ-035 The output holding register SHALL be a single sub-module lstm_out_slot (1-entry valid/ready buffer); everything else SHALL be inline.

Verification
REQ-036 Config: cfg_gate=2, cfg_sel=1, cfg_data=0x0100 -> cell_weight_h_valid=4'b0100 for one cycle with lane 2=0x0100.
REQ-037 Sequence: seq_len=3, clear_state=1, with the cell model -> one INIT pulse of h=C=0, three m_y beats, done once, final_c = third cell_c_out.
REQ-038 Backpressure: m_y_ready=0 for 20 cycles after the first output -> s_x_ready=0 throughout; the sequence resumes after release with no loss or duplication.
REQ-039 seq_len=0 -> done two cycles after start; no cell_x_valid.
REQ-040 Stuck cell (cell_valid never asserts) -> error=1 TIMEOUT cycles after accept, FSM in IDLE, no done.
REQ-041 rst asserted in WAIT -> all outputs 0 next cycle; a fresh start then completes normally.

Source files
------------

// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM sequence controller and its cell.
package lstm_pkg;

    typedef enum logic [1:0] {
        GATE_I = 2'd0,
        GATE_F = 2'd1,
        GATE_G = 2'd2,
        GATE_O = 2'd3
    } gate_e;

    typedef enum logic [1:0] {
        SEL_WEIGHT_X = 2'd0,
        SEL_WEIGHT_H = 2'd1,
        SEL_BIAS_X   = 2'd2,
        SEL_BIAS_H   = 2'd3
    } cfg_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int CELL_LATENCY = 7;

endpackage

// File: rtl/lstm_out_slot.sv
// One-entry valid/ready holding register for the h output stream.
module lstm_out_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Accept a new word when empty or when the held word leaves this cycle.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lstm_seq_ctrl.sv
// Sequencer that streams samples through an external LSTM cell, loads its
// coefficients, optionally zeroes h/C at start, and watches for a stuck cell.
module lstm_seq_ctrl
    import lstm_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         cfg_gate,
    input  logic [1:0]         cfg_sel,
    input  logic [WIDTH-1:0]   cfg_data,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               start,
    input  logic [LEN_W-1:0]   seq_len,
    input  logic               clear_state,
    output logic               busy,
    output logic               done,
    output logic               error,
    input  logic [WIDTH-1:0]   s_x,
    input  logic               s_x_valid,
    output logic               s_x_ready,
    output logic [WIDTH-1:0]   m_y,
    output logic               m_y_valid,
    input  logic               m_y_ready,
    output logic [WIDTH-1:0]   final_c,
    input  logic               cell_ready,
    output logic [WIDTH-1:0]   cell_x,
    output logic [WIDTH-1:0]   cell_h,
    output logic [WIDTH-1:0]   cell_c,
    output logic               cell_x_valid,
    output logic               cell_h_valid,
    output logic               cell_c_valid,
    output logic [4*WIDTH-1:0] cell_weight_x,
    output logic [4*WIDTH-1:0] cell_weight_h,
    output logic [4*WIDTH-1:0] cell_bias_x,
    output logic [4*WIDTH-1:0] cell_bias_h,
    output logic [3:0]         cell_weight_x_valid,
    output logic [3:0]         cell_weight_h_valid,
    output logic [3:0]         cell_bias_x_valid,
    output logic [3:0]         cell_bias_h_valid,
    input  logic [WIDTH-1:0]   cell_y,
    input  logic [WIDTH-1:0]   cell_c_out,
    input  logic               cell_valid
);

    localparam int N_LANES = int'(GATE_O) + 1;
    // Wide enough to count past the nominal cell latency even if TIMEOUT is set low.
    localparam int TMO_W = $clog2((TIMEOUT > CELL_LATENCY ? TIMEOUT : CELL_LATENCY) + 1);

    state_e           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic [TMO_W-1:0] r_tmo;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic             r_init_vld;
    logic [WIDTH-1:0] r_final_c;

    logic                                 w_cfg_hs;
    logic                                 w_x_hs;
    logic                                 w_capture;
    logic                                 w_slot_ready;
    logic                                 w_last;
    logic [N_LANES-1:0]                   w_gate_onehot;
    logic [3:0][N_LANES*WIDTH-1:0]        w_lane_data;
    logic [3:0][N_LANES-1:0]              w_lane_vld;

    assign cfg_ready     = (r_state == ST_IDLE) && cell_ready;
    assign w_cfg_hs      = cfg_valid && cfg_ready;
    assign w_gate_onehot = N_LANES'(1) << cfg_gate;

    // One register set per coefficient target; the valid strobe lives one cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
            logic [WIDTH-1:0]   r_data;
            logic [N_LANES-1:0] r_vld;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= '0;
                    r_vld  <= '0;
                end else begin
                    r_vld <= '0;
                    if (w_cfg_hs && cfg_sel == 2'(gi)) begin
                        r_data <= cfg_data;
                        r_vld  <= w_gate_onehot;
                    end
                end
            end

            assign w_lane_data[gi] = {N_LANES{r_data}};
            assign w_lane_vld[gi]  = r_vld;
        end
    endgenerate

    assign cell_weight_x       = w_lane_data[SEL_WEIGHT_X];
    assign cell_weight_h       = w_lane_data[SEL_WEIGHT_H];
    assign cell_bias_x         = w_lane_data[SEL_BIAS_X];
    assign cell_bias_h         = w_lane_data[SEL_BIAS_H];
    assign cell_weight_x_valid = w_lane_vld[SEL_WEIGHT_X];
    assign cell_weight_h_valid = w_lane_vld[SEL_WEIGHT_H];
    assign cell_bias_x_valid   = w_lane_vld[SEL_BIAS_X];
    assign cell_bias_h_valid   = w_lane_vld[SEL_BIAS_H];

    // A pending output blocks the next issue so m_y never needs more than one slot.
    assign s_x_ready    = (r_state == ST_ISSUE) && cell_ready && !m_y_valid;
    assign cell_x_valid = s_x_ready && s_x_valid;
    assign cell_x       = s_x;
    assign w_x_hs       = cell_x_valid;

    assign cell_h       = '0;
    assign cell_c       = '0;
    assign cell_h_valid = r_init_vld;
    assign cell_c_valid = r_init_vld;

    assign w_capture = (r_state == ST_WAIT) && cell_valid && w_slot_ready;
    assign w_last    = (r_cnt + LEN_W'(1)) == r_len;

    assign busy    = r_busy;
    assign done    = r_done;
    assign error   = r_error;
    assign final_c = r_final_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_tmo      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_init_vld <= 1'b0;
            r_final_c  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_init_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_error <= 1'b0;
                        r_cnt   <= '0;
                        r_len   <= seq_len;
                        r_tmo   <= '0;
                        if (seq_len == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= clear_state ? ST_INIT : ST_ISSUE;
                        end
                    end
                end
                ST_INIT: begin
                    if (cell_ready) begin
                        r_init_vld <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_x_hs) begin
                        r_tmo   <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_capture) begin
                        r_cnt     <= r_cnt + LEN_W'(1);
                        r_final_c <= cell_c_out;
                        r_state   <= w_last ? ST_DONE : ST_ISSUE;
                    end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    lstm_out_slot #(
        .WIDTH (WIDTH)
    ) u_out_slot (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_capture),
        .i_data  (cell_y),
        .o_ready (w_slot_ready),
        .o_valid (m_y_valid),
        .o_data  (m_y),
        .i_ready (m_y_ready)
    );

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Directed bench for lstm_seq_ctrl with a fixed-latency cell model and a
// queue-based model of the expected h stream and final cell state.
module tb_lstm_seq_ctrl;
    import lstm_pkg::*;

    localparam int WIDTH   = 16;
    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [1:0]         cfg_gate, cfg_sel;
    logic [WIDTH-1:0]   cfg_data;
    logic               cfg_valid, cfg_ready;
    logic               start, clear_state, busy, done, error;
    logic [LEN_W-1:0]   seq_len;
    logic [WIDTH-1:0]   s_x, m_y, final_c;
    logic               s_x_valid, s_x_ready, m_y_valid, m_y_ready;
    logic               cell_ready, cell_x_valid, cell_h_valid, cell_c_valid, cell_valid;
    logic [WIDTH-1:0]   cell_x, cell_h, cell_c, cell_y, cell_c_out;
    logic [4*WIDTH-1:0] cell_weight_x, cell_weight_h, cell_bias_x, cell_bias_h;
    logic [3:0]         cell_weight_x_valid, cell_weight_h_valid, cell_bias_x_valid, cell_bias_h_valid;

    lstm_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cfg_gate(cfg_gate), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .start(start), .seq_len(seq_len), .clear_state(clear_state),
        .busy(busy), .done(done), .error(error),
        .s_x(s_x), .s_x_valid(s_x_valid), .s_x_ready(s_x_ready),
        .m_y(m_y), .m_y_valid(m_y_valid), .m_y_ready(m_y_ready),
        .final_c(final_c), .cell_ready(cell_ready),
        .cell_x(cell_x), .cell_h(cell_h), .cell_c(cell_c),
        .cell_x_valid(cell_x_valid), .cell_h_valid(cell_h_valid), .cell_c_valid(cell_c_valid),
        .cell_weight_x(cell_weight_x), .cell_weight_h(cell_weight_h),
        .cell_bias_x(cell_bias_x), .cell_bias_h(cell_bias_h),
        .cell_weight_x_valid(cell_weight_x_valid), .cell_weight_h_valid(cell_weight_h_valid),
        .cell_bias_x_valid(cell_bias_x_valid), .cell_bias_h_valid(cell_bias_h_valid),
        .cell_y(cell_y), .cell_c_out(cell_c_out), .cell_valid(cell_valid)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // The cell under test-bench control: y = x + 1.0, C = x ^ 0x5A5A.
    function automatic logic [15:0] cell_fy(input logic [15:0] x);
        return x + 16'h0100;
    endfunction
    function automatic logic [15:0] cell_fc(input logic [15:0] x);
        return x ^ 16'h5A5A;
    endfunction

    // Model state and event counters maintained by the compare process.
    logic [15:0] exp_q[$];
    logic [15:0] y_log[$];
    logic [15:0] exp_c = '0;
    int  init_cnt = 0, xi_cnt = 0, y_cnt = 0, done_cnt = 0, cxv_cnt = 0;
    int  cyc = 0, hs_cyc = 0, err_cyc = 0;
    bit  err_prev = 0;
    bit  x_hs = 0, cell_hs = 0, cm_kill = 0, stuck = 0;
    logic [15:0] cell_x_cap = '0;

    // Sample source.
    logic [15:0] src[8];
    int src_n = 0, src_idx = 0;

    // Compare process: everything sampled on the falling edge.
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            x_hs       = s_x_valid && s_x_ready;
            cell_hs    = cell_x_valid && cell_ready && !stuck;
            cell_x_cap = cell_x;
            cm_kill    = rst;
            if (!rst) begin
                chk("cell_x_valid_rule", cell_x_valid, s_x_valid && s_x_ready);
                if (m_y_valid) chk("no_issue_while_y_pending", s_x_ready, 0);
                if (cell_x_valid) begin
                    cxv_cnt++;
                    chk("cell_x_passthru", cell_x, s_x);
                end
                if (cell_h_valid || cell_c_valid) begin
                    init_cnt++;
                    chk("init_pulse", {cell_h_valid, cell_c_valid, cell_h, cell_c}, {2'b11, 32'h0});
                end
                if (m_y_valid && m_y_ready) begin
                    y_cnt++;
                    y_log.push_back(m_y);
                    if (exp_q.size() == 0) chk("m_y_unexpected_beat", 1, 0);
                    else chk("m_y_beat", m_y, exp_q.pop_front());
                end
                if (x_hs) begin
                    xi_cnt++;
                    hs_cyc = cyc;
                    exp_q.push_back(cell_fy(s_x));
                    exp_c = cell_fc(s_x);
                end
                if (done) begin
                    done_cnt++;
                    chk("final_c_at_done", final_c, exp_c);
                end
                if (error && !err_prev) err_cyc = cyc;
            end
            err_prev = error;
        end
    end

    // Cell model: responds CELL_LATENCY cycles after each accepted x.
    int cm_cnt = 0;
    logic [15:0] cm_x = '0;
    initial begin : cell_model
        cell_valid = 1'b0; cell_y = '0; cell_c_out = '0;
        forever begin
            @(posedge clk); #1;
            cell_valid = 1'b0;
            if (cm_kill) begin
                cm_cnt = 0;
            end else begin
                if (cm_cnt > 0) begin
                    cm_cnt--;
                    if (cm_cnt == 0) begin
                        cell_valid = 1'b1;
                        cell_y     = cell_fy(cm_x);
                        cell_c_out = cell_fc(cm_x);
                    end
                end
                if (cell_hs) begin
                    cm_cnt = CELL_LATENCY;
                    cm_x   = cell_x_cap;
                end
            end
        end
    end

    initial begin : source
        s_x_valid = 1'b0; s_x = '0;
        forever begin
            @(posedge clk); #2;
            if (x_hs) src_idx++;
            if (src_idx < src_n) begin
                s_x_valid = 1'b1;
                s_x       = src[src_idx];
            end else begin
                s_x_valid = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic load_src(input logic [15:0] a, b, c, d, input int n);
        src[0] = a; src[1] = b; src[2] = c; src[3] = d;
        src_idx = 0;
        src_n   = n;
    endtask

    task automatic run_start(input logic [LEN_W-1:0] len, input logic clr);
        start = 1'b1; seq_len = len; clear_state = clr;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) step();
        chk(name, done_cnt > d0, 1);
    endtask

    int d0, x0, y0, i0, c0;
    logic [15:0] held, saved_c;

    initial begin : main
        rst = 1'b1; cfg_gate = '0; cfg_sel = '0; cfg_data = '0; cfg_valid = 1'b0;
        start = 1'b0; seq_len = '0; clear_state = 1'b0;
        m_y_ready = 1'b1; cell_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_m_y", {m_y_valid, m_y}, 0);
        chk("rst_final_c", final_c, 0);
        chk("rst_cell_valids", {cell_x_valid, cell_h_valid, cell_c_valid, cell_weight_x_valid,
            cell_weight_h_valid, cell_bias_x_valid, cell_bias_h_valid}, 0);
        chk("rst_cell_coeffs", {cell_weight_x, cell_weight_h}, 0);
        chk("rst_cfg_ready", cfg_ready, 1);

        // Coefficient load: gate g, weight_h, 1.0
        step();
        cfg_gate = 2'd2; cfg_sel = 2'd1; cfg_data = 16'h0100; cfg_valid = 1'b1;
        @(negedge clk);
        chk("cfg_ready_idle", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("cfg_wh_valid", cell_weight_h_valid, 4'b0100);
        chk("cfg_wh_lane2", cell_weight_h[32 +: 16], 16'h0100);
        chk("cfg_other_valids", {cell_weight_x_valid, cell_bias_x_valid, cell_bias_h_valid}, 0);
        step();
        @(negedge clk);
        chk("cfg_wh_valid_one_cycle", cell_weight_h_valid, 0);
        // Gate i, bias_x, -0.5
        step();
        cfg_gate = 2'd0; cfg_sel = 2'd2; cfg_data = 16'hFF80; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("cfg_bx_valid", cell_bias_x_valid, 4'b0001);
        chk("cfg_bx_lane0", cell_bias_x[0 +: 16], 16'hFF80);
        step();
        cell_ready = 1'b0;
        @(negedge clk);
        chk("cfg_ready_needs_cell", cfg_ready, 0);
        step();
        cell_ready = 1'b1;

        // Three-sample sequence with state clear
        load_src(16'h0010, 16'h0020, 16'h0030, 16'h0000, 3);
        run_start(3, 1'b1);
        @(negedge clk);
        chk("seq3_busy", busy, 1);
        wait_done("seq3_done_seen", 300);
        @(negedge clk);
        chk("seq3_busy_dropped", busy, 0);
        repeat (3) step();
        chk("seq3_init_pulses", init_cnt, 1);
        chk("seq3_y_beats", y_cnt, 3);
        chk("seq3_done_pulses", done_cnt, 1);
        chk("seq3_y0_literal", y_log[0], 16'h0110);
        chk("seq3_y2_literal", y_log[2], 16'h0130);
        chk("seq3_final_c_literal", final_c, 16'h5A6A);

        // Output still pending after done
        m_y_ready = 1'b0;
        y0 = y_cnt;
        load_src(16'h0040, 16'h0000, 16'h0000, 16'h0000, 1);
        run_start(1, 1'b0);
        wait_done("pend_done_seen", 200);
        step();
        @(negedge clk);
        chk("pend_m_y_held", {m_y_valid, m_y}, {1'b1, 16'h0140});
        chk("pend_busy", busy, 0);
        step();
        m_y_ready = 1'b1;
        repeat (2) step();
        chk("pend_consumed", y_cnt - y0, 1);

        // Backpressure for 20 cycles after the first output
        x0 = xi_cnt; y0 = y_cnt; i0 = init_cnt; d0 = done_cnt;
        m_y_ready = 1'b0;
        load_src(16'h0100, 16'h0200, 16'h0300, 16'h0400, 4);
        run_start(4, 1'b0);
        for (int i = 0; i < 100 && !m_y_valid; i++) step();
        chk("bp_first_output", m_y_valid, 1);
        held = m_y;
        chk("bp_held_literal", held, 16'h0200);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_s_x_ready_low", s_x_ready, 0);
            chk("bp_m_y_stable", m_y, held);
            step();
        end
        chk("bp_no_issue_during_hold", xi_cnt - x0, 1);
        m_y_ready = 1'b1;
        wait_done("bp_done_seen", 300);
        repeat (3) step();
        chk("bp_issued", xi_cnt - x0, 4);
        chk("bp_y_beats", y_cnt - y0, 4);
        chk("bp_no_init", init_cnt - i0, 0);
        chk("bp_one_done", done_cnt - d0, 1);

        // Stuck cell -> timeout error, no done
        stuck = 1;
        saved_c = exp_c;
        d0 = done_cnt;
        load_src(16'h0777, 16'h0000, 16'h0000, 16'h0000, 1);
        run_start(1, 1'b0);
        for (int i = 0; i < 100 && !error; i++) step();
        step();
        chk("stuck_error_set", error, 1);
        // hs_cyc is the falling edge just before the accept edge, so the
        // error first shows TIMEOUT+1 falling edges later.
        chk("stuck_error_latency", err_cyc - hs_cyc, TIMEOUT + 1);
        chk("stuck_no_done", done_cnt - d0, 0);
        chk("stuck_busy_low", busy, 0);
        chk("stuck_back_in_idle", cfg_ready, 1);
        repeat (3) step();
        chk("stuck_error_sticky", error, 1);
        exp_q.delete();
        exp_c = saved_c;
        stuck = 0;

        // Zero-length sequence: done two cycles after start, no cell traffic
        c0 = cxv_cnt;
        d0 = done_cnt;
        start = 1'b1; seq_len = '0; clear_state = 1'b1;
        @(negedge clk);
        chk("len0_done_t0", done, 0);
        step();
        start = 1'b0;
        @(negedge clk);
        chk("len0_done_t1", done, 0);
        chk("len0_error_cleared", error, 0);
        chk("len0_busy_low", busy, 0);
        step();
        @(negedge clk);
        chk("len0_done_t2", done, 1);
        step();
        @(negedge clk);
        chk("len0_done_single", done, 0);
        step();
        chk("len0_no_cell_x", cxv_cnt - c0, 0);
        chk("len0_one_done", done_cnt - d0, 1);

        // Reset while waiting on the cell
        d0 = done_cnt;
        x0 = xi_cnt;
        load_src(16'h0011, 16'h0022, 16'h0000, 16'h0000, 2);
        run_start(2, 1'b1);
        for (int i = 0; i < 50 && xi_cnt == x0; i++) step();
        chk("rstw_reached_wait", xi_cnt - x0, 1);
        rst = 1'b1;
        src_n = 0;
        step();
        @(negedge clk);
        chk("rstw_status", {busy, done, error}, 0);
        chk("rstw_m_y", {m_y_valid, m_y}, 0);
        chk("rstw_final_c", final_c, 0);
        chk("rstw_cell_valids", {cell_x_valid, cell_h_valid, cell_c_valid, cell_weight_x_valid,
            cell_weight_h_valid, cell_bias_x_valid, cell_bias_h_valid}, 0);
        chk("rstw_coeffs_cleared", {cell_weight_h, cell_bias_x}, 0);
        step();
        rst = 1'b0;
        exp_q.delete();
        exp_c = '0;
        repeat (2) step();
        chk("rstw_no_done", done_cnt - d0, 0);

        y0 = y_cnt; i0 = init_cnt;
        load_src(16'h0005, 16'h0006, 16'h0000, 16'h0000, 2);
        run_start(2, 1'b1);
        wait_done("fresh_done_seen", 200);
        repeat (3) step();
        chk("fresh_y_beats", y_cnt - y0, 2);
        chk("fresh_init_pulse", init_cnt - i0, 1);
        chk("fresh_final_c_literal", final_c, 16'h5A5C);
        chk("model_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
